// File: rtl/rcdc_pkg.sv
// Shared defaults, phase type and a popcount helper for the related-clock 3:2 launch stage.
package rcdc_pkg;

  localparam int RCDC_RATIO_M_DEF = 3;
  localparam logic [RCDC_RATIO_M_DEF-1:0] RCDC_LAUNCH_MASK_DEF = 3'b101;

  typedef logic [$clog2(RCDC_RATIO_M_DEF)-1:0] phase_t;

  // Launch slots per frame; sets the sustainable word rate.
  function automatic int unsigned rcdc_popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/rcdc_fifo.sv
// Synchronous FIFO, registered storage, head read from memory (no push-to-head bypass).
// Push is ignored when full and pop when empty; fill is a separate up/down counter.
module rcdc_fifo
  import rcdc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_3g,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_dat_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic              push_ok, pop_ok;

  assign full_o  = (fill_q == (AW+1)'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign fill_o  = fill_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_3g) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset: the pointers and fill define what is valid.
  always_ff @(posedge clk_3g) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/rcdc_launch_3g.sv
// Fast-side launch stage: buffers words and updates tx_* only at the end of launch phases,
// one cycle after the launch decision; in_ready drops when the FIFO is full.
module rcdc_launch_3g
  import rcdc_pkg::*;
#(
  parameter int                   DATA_W      = 8,
  parameter int                   RATIO_M     = RCDC_RATIO_M_DEF,
  parameter logic [RATIO_M-1:0]   LAUNCH_MASK = RCDC_LAUNCH_MASK_DEF,
  parameter int                   DEPTH       = 4
) (
  input  logic                        clk_3g,
  input  logic                        rst,
  input  logic                        sync_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        frame_o,
  output logic [$clog2(RATIO_M)-1:0]  phase_o,
  output logic [$clog2(DEPTH):0]      fill_o
);

  localparam int          PH_W     = $clog2(RATIO_M);
  localparam int unsigned LAUNCHES = rcdc_popcount(32'(LAUNCH_MASK));

  if (LAUNCHES == 0) begin : g_bad_mask
    $fatal(1, "rcdc_launch_3g: LAUNCH_MASK must have at least one launch phase");
  end
  if (RATIO_M < 2) begin : g_bad_ratio
    $fatal(1, "rcdc_launch_3g: RATIO_M must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "rcdc_launch_3g: DEPTH must be a power of 2, at least 2");
  end

  logic [PH_W-1:0]   phase_q, phase_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              launch, push, pop, full, empty;
  logic [DATA_W-1:0] head;

  assign launch   = LAUNCH_MASK[phase_q];
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = launch & ~empty;

  rcdc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_3g     (clk_3g),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (in_data),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .fill_o     (fill_o)
  );

  // sync_i only steers the next phase; this cycle still launches on the current one.
  always_comb begin
    phase_d = phase_q + PH_W'(1);
    if (sync_i || phase_q == PH_W'(RATIO_M - 1)) phase_d = '0;
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (launch) begin
      tx_valid_d = ~empty;
      if (!empty) tx_data_d = head;
    end
  end

  always_ff @(posedge clk_3g) begin
    if (rst) begin
      phase_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign phase_o  = phase_q;
  assign frame_o  = (phase_q == PH_W'(RATIO_M - 1));

endmodule

// File: tb/tb_rcdc_launch_3g.sv
// Bench for rcdc_launch_3g: vector table, directed corner sequences, and random traffic against a queue model.
module tb_rcdc_launch_3g;

  localparam int         DATA_W  = 8;
  localparam int         RATIO_M = 3;
  localparam logic [2:0] MASK    = 3'b101;
  localparam int         DEPTH   = 4;

  logic              clk_3g = 1'b0;
  logic              rst = 1'b1;
  logic              sync_i = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              frame_o;
  logic [1:0]        phase_o;
  logic [2:0]        fill_o;

  int n_cmp = 0;
  int n_err = 0;

  rcdc_launch_3g #(
    .DATA_W      (DATA_W),
    .RATIO_M     (RATIO_M),
    .LAUNCH_MASK (MASK),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_3g   (clk_3g),
    .rst      (rst),
    .sync_i   (sync_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .frame_o  (frame_o),
    .phase_o  (phase_o),
    .fill_o   (fill_o)
  );

  always #5 clk_3g = ~clk_3g;

  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
    logic [1:0] ph;
    logic       frm;
    logic       rdy;
    logic [2:0] fill;
    logic       tv;
    logic [7:0] td;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; all sampling and driving happens 1 ns after the edge.
  task automatic step();
    @(posedge clk_3g);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync_i = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    step();
    rst = 1'b0;
  endtask

  // Random-phase model state
  logic [7:0] q[$];
  int         since;
  logic       m_tv;
  logic [7:0] m_td;
  logic [7:0] prev_td;
  logic       prev_allow;

  initial begin
    tbl[0]  = '{1'b1, 8'h10, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h11, 2'd1, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h12, 2'd2, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h13, 2'd0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h10};
    tbl[4]  = '{1'b1, 8'h14, 2'd1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 8'h15, 2'd2, 1'b1, 1'b1, 3'd3, 1'b1, 8'h11};
    tbl[6]  = '{1'b1, 8'h16, 2'd0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h12};
    tbl[7]  = '{1'b1, 8'h17, 2'd1, 1'b0, 1'b1, 3'd3, 1'b1, 8'h13};
    tbl[8]  = '{1'b1, 8'h18, 2'd2, 1'b1, 1'b0, 3'd4, 1'b1, 8'h13};
    tbl[9]  = '{1'b1, 8'h18, 2'd0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h14};
    tbl[10] = '{1'b1, 8'h19, 2'd1, 1'b0, 1'b1, 3'd3, 1'b1, 8'h15};

    // Idle after reset release
    do_reset();
    for (int k = 0; k < 9; k++) begin
      check("idle_phase", phase_o, k % 3);
      check("idle_frame", frame_o, (k % 3) == 2);
      check("idle_tx_valid", tx_valid, 0);
      check("idle_tx_data", tx_data, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_fill", fill_o, 0);
      step();
    end

    // Continuous push from cycle 0
    do_reset();
    for (int k = 0; k < 11; k++) begin
      in_valid = tbl[k].vld;
      in_data  = tbl[k].dat;
      check("burst_phase", phase_o, tbl[k].ph);
      check("burst_frame", frame_o, tbl[k].frm);
      check("burst_in_ready", in_ready, tbl[k].rdy);
      check("burst_fill", fill_o, tbl[k].fill);
      check("burst_tx_valid", tx_valid, tbl[k].tv);
      check("burst_tx_data", tx_data, tbl[k].td);
      step();
    end

    // Reset while full and with a push pending
    check("midrst_fill_before", fill_o, 4);
    check("midrst_ready_before", in_ready, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h1A;
    step();
    rst = 1'b0;
    check("midrst_fill", fill_o, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_phase", phase_o, 0);
    check("midrst_in_ready", in_ready, 1);
    in_data = 8'h77;
    step();
    in_valid = 1'b0;
    check("midrst_c1_tx_valid", tx_valid, 0);
    step(); step();
    check("midrst_c3_tx_valid", tx_valid, 1);
    check("midrst_c3_tx_data", tx_data, 8'h77);
    step(); step(); step();
    check("midrst_c6_tx_valid", tx_valid, 0);
    check("midrst_c6_tx_data", tx_data, 8'h77);

    // Single push into an empty FIFO at phase 0
    do_reset();
    step(); step(); step();
    check("single_c3_phase", phase_o, 0);
    in_valid = 1'b1;
    in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    check("single_c4_tx_valid", tx_valid, 0);
    step();
    check("single_c5_tx_valid", tx_valid, 0);
    check("single_c5_fill", fill_o, 1);
    step();
    check("single_c6_tx_valid", tx_valid, 1);
    check("single_c6_tx_data", tx_data, 8'hA5);
    step();
    check("single_c7_tx_valid", tx_valid, 0);
    check("single_c7_tx_data", tx_data, 8'hA5);

    // Phase realignment at cycle 4
    do_reset();
    step(); step(); step(); step();
    check("sync_c4_phase", phase_o, 1);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check("sync_c5_phase", phase_o, 0);
    check("sync_c5_frame", frame_o, 0);
    in_valid = 1'b1;
    in_data = 8'h5C;
    step();
    in_valid = 1'b0;
    check("sync_c6_phase", phase_o, 1);
    step();
    check("sync_c7_phase", phase_o, 2);
    check("sync_c7_frame", frame_o, 1);
    check("sync_c7_tx_valid", tx_valid, 0);
    step();
    check("sync_c8_tx_valid", tx_valid, 1);
    check("sync_c8_tx_data", tx_data, 8'h5C);

    // Random traffic against a queue-based model
    do_reset();
    q.delete();
    since = 0;
    m_tv = 1'b0;
    m_td = '0;
    prev_td = '0;
    prev_allow = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      int   ph;
      logic r, s, v, exp_rdy;
      logic [7:0] d;
      ph = since % RATIO_M;
      exp_rdy = (q.size() < DEPTH);
      check("rnd_phase", phase_o, ph);
      check("rnd_frame", frame_o, ph == RATIO_M - 1);
      check("rnd_in_ready", in_ready, exp_rdy);
      check("rnd_fill", fill_o, q.size());
      check("rnd_tx_valid", tx_valid, m_tv);
      check("rnd_tx_data", tx_data, m_td);
      if (tx_data !== prev_td) check("rnd_change_only_after_launch", prev_allow, 1);
      prev_td = tx_data;

      r = ($urandom_range(0, 799) == 0);
      s = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 8);
      d = 8'($urandom);
      rst = r;
      sync_i = s;
      in_valid = v;
      in_data = d;

      prev_allow = MASK[ph] || r;
      if (r) begin
        q.delete();
        since = 0;
        m_tv = 1'b0;
        m_td = '0;
      end else begin
        if (MASK[ph]) begin
          if (q.size() > 0) begin
            m_td = q.pop_front();
            m_tv = 1'b1;
          end else begin
            m_tv = 1'b0;
          end
        end
        if (v && exp_rdy) q.push_back(d);
        since = s ? 0 : since + 1;
      end
      step();
    end
    rst = 1'b0;
    sync_i = 1'b0;
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
